// File: rtl/soc_video_ctrl.sv
// CPU-side video control: colour palette, double-buffered palette index driving rgb_data,
// frame/line counters fed by pixel-domain toggles, and a maskable level interrupt.
module soc_video_ctrl #(
    parameter int PAL_DEPTH = 16,
    parameter int COLOR_W   = 24,
    parameter int FCNT_W    = 16
) (
    input  logic               clk_cpu,
    input  logic               n_reset,
    input  logic               sel,
    input  logic [3:0]         wren,
    input  logic [23:0]        address,
    input  logic [31:0]        video_data_in,
    output logic [31:0]        video_data_out,
    input  logic               line_end_tgl,
    input  logic               frame_end_tgl,
    output logic [COLOR_W-1:0] rgb_data,
    output logic               irq
);
    localparam int IW = $clog2(PAL_DEPTH);

    localparam logic [5:0] REG_CTRL   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_IRQ_EN = 6'h02;
    localparam logic [5:0] REG_LINE   = 6'h03;
    localparam logic [5:0] REG_FRAME  = 6'h04;

    logic [1:0]         sync_line_q, sync_line_d, sync_frame_q, sync_frame_d;
    logic               hist_line_q, hist_line_d, hist_frame_q, hist_frame_d;
    logic               line_evt_q, line_evt_d, frame_evt_q, frame_evt_d;
    logic               enable_q, enable_d, commit_mode_q, commit_mode_d;
    logic [IW-1:0]      shadow_q, shadow_d, active_q, active_d;
    logic               commit_pend_q, commit_pend_d;
    logic               frame_pend_q, frame_pend_d, line_pend_q, line_pend_d;
    logic [1:0]         irq_en_q, irq_en_d;
    logic [9:0]         line_cnt_q, line_cnt_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [COLOR_W-1:0] palette_q [PAL_DEPTH];
    logic [COLOR_W-1:0] palette_d [PAL_DEPTH];
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               irq_q, irq_d;

    logic [5:0]         word;
    logic               wr, pal_hit, ctrl_we, status_we, irq_en_we, pal_we;
    logic [IW-1:0]      pal_idx;
    logic [COLOR_W-1:0] pal_mask;
    logic [1:0]         status_clr;
    logic               unused_in;

    assign word      = address[7:2];
    assign wr        = sel && (wren != 4'b0000);
    assign pal_hit   = word[5] && (int'(word[4:0]) < PAL_DEPTH);
    assign pal_idx   = IW'(word[4:0]);
    assign ctrl_we   = wr && (word == REG_CTRL);
    assign status_we = wr && (word == REG_STATUS);
    assign irq_en_we = wr && (word == REG_IRQ_EN);
    assign pal_we    = wr && pal_hit;
    assign unused_in = ^{address[23:8], address[1:0], video_data_in, wren};

    // Read mux is purely combinational on the address; sel is deliberately ignored.
    always_comb begin
        video_data_out = '0;
        case (word)
            REG_CTRL: begin
                video_data_out[0]       = enable_q;
                video_data_out[1]       = commit_mode_q;
                video_data_out[8 +: IW] = shadow_q;
            end
            REG_STATUS: begin
                video_data_out[0]       = frame_pend_q;
                video_data_out[1]       = line_pend_q;
                video_data_out[2]       = commit_pend_q;
                video_data_out[8 +: IW] = active_q;
            end
            REG_IRQ_EN: video_data_out[1:0]        = irq_en_q;
            REG_LINE:   video_data_out[9:0]        = line_cnt_q;
            REG_FRAME:  video_data_out[FCNT_W-1:0] = frame_cnt_q;
            default:    video_data_out = '0;
        endcase
        if (pal_hit)
            video_data_out[COLOR_W-1:0] = palette_q[pal_idx];
    end

    always_comb begin
        sync_line_d  = {sync_line_q[0], line_end_tgl};
        sync_frame_d = {sync_frame_q[0], frame_end_tgl};
        hist_line_d  = sync_line_q[1];
        hist_frame_d = sync_frame_q[1];
        line_evt_d   = sync_line_q[1] ^ hist_line_q;
        frame_evt_d  = sync_frame_q[1] ^ hist_frame_q;

        enable_d      = enable_q;
        commit_mode_d = commit_mode_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        commit_pend_d = commit_pend_q;
        irq_en_d      = irq_en_q;
        line_cnt_d    = line_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        palette_d     = palette_q;
        pal_mask      = '0;
        status_clr    = '0;

        if (ctrl_we) begin
            if (wren[0]) begin
                enable_d      = video_data_in[0];
                commit_mode_d = video_data_in[1];
            end
            if (wren[1])
                shadow_d = video_data_in[8 +: IW];
        end

        // A CTRL write in the same cycle as a frame commit overrides it: the frame
        // moves the old shadow into active, the write then re-arms or loads directly.
        if (frame_evt_q && commit_pend_q) begin
            active_d      = shadow_q;
            commit_pend_d = 1'b0;
        end
        if (ctrl_we) begin
            if (commit_mode_d) begin
                commit_pend_d = 1'b1;
            end else begin
                active_d      = shadow_d;
                commit_pend_d = 1'b0;
            end
        end

        if (status_we && wren[0])
            status_clr = video_data_in[1:0];
        frame_pend_d = (frame_pend_q & ~status_clr[0]) | frame_evt_q;
        line_pend_d  = (line_pend_q & ~status_clr[1]) | line_evt_q;

        if (irq_en_we && wren[0])
            irq_en_d = video_data_in[1:0];

        if (frame_evt_q) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            line_cnt_d  = '0;
        end else if (line_evt_q && (line_cnt_q != 10'h3FF)) begin
            line_cnt_d = line_cnt_q + 10'd1;
        end

        for (int b = 0; b < COLOR_W; b++)
            pal_mask[b] = wren[b / 8];
        if (pal_we)
            palette_d[pal_idx] = (palette_q[pal_idx] & ~pal_mask)
                               | (video_data_in[COLOR_W-1:0] & pal_mask);

        rgb_d = enable_q ? palette_q[active_q] : '0;
        irq_d = |({line_pend_q, frame_pend_q} & irq_en_q);
    end

    always_ff @(posedge clk_cpu or negedge n_reset) begin
        if (!n_reset) begin
            sync_line_q   <= '0;
            sync_frame_q  <= '0;
            hist_line_q   <= 1'b0;
            hist_frame_q  <= 1'b0;
            line_evt_q    <= 1'b0;
            frame_evt_q   <= 1'b0;
            enable_q      <= 1'b0;
            commit_mode_q <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            commit_pend_q <= 1'b0;
            frame_pend_q  <= 1'b0;
            line_pend_q   <= 1'b0;
            irq_en_q      <= '0;
            line_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            for (int i = 0; i < PAL_DEPTH; i++)
                palette_q[i] <= '0;
            rgb_q         <= '0;
            irq_q         <= 1'b0;
        end else begin
            sync_line_q   <= sync_line_d;
            sync_frame_q  <= sync_frame_d;
            hist_line_q   <= hist_line_d;
            hist_frame_q  <= hist_frame_d;
            line_evt_q    <= line_evt_d;
            frame_evt_q   <= frame_evt_d;
            enable_q      <= enable_d;
            commit_mode_q <= commit_mode_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            commit_pend_q <= commit_pend_d;
            frame_pend_q  <= frame_pend_d;
            line_pend_q   <= line_pend_d;
            irq_en_q      <= irq_en_d;
            line_cnt_q    <= line_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            palette_q     <= palette_d;
            rgb_q         <= rgb_d;
            irq_q         <= irq_d;
        end
    end

    assign rgb_data = rgb_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_soc_video_ctrl.sv
// Scoreboard bench for soc_video_ctrl: expectations are queued as stimulus is driven
// and popped when the DUT output they describe becomes observable.
module tb_soc_video_ctrl;
    logic        clk_cpu = 1'b0;
    logic        n_reset;
    logic        sel;
    logic [3:0]  wren;
    logic [23:0] address;
    logic [31:0] video_data_in;
    logic [31:0] video_data_out;
    logic        line_end_tgl;
    logic        frame_end_tgl;
    logic [23:0] rgb_data;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_frames = 0;
    logic [31:0] obs;

    soc_video_ctrl #(.PAL_DEPTH(16), .COLOR_W(24), .FCNT_W(16)) dut (
        .clk_cpu       (clk_cpu),
        .n_reset       (n_reset),
        .sel           (sel),
        .wren          (wren),
        .address       (address),
        .video_data_in (video_data_in),
        .video_data_out(video_data_out),
        .line_end_tgl  (line_end_tgl),
        .frame_end_tgl (frame_end_tgl),
        .rgb_data      (rgb_data),
        .irq           (irq)
    );

    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_cpu);
        #1;
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d,
                             input logic [3:0] w, input logic s);
        address       = a;
        video_data_in = d;
        wren          = w;
        sel           = s;
        @(posedge clk_cpu);
        #1;
        sel  = 1'b0;
        wren = 4'b0000;
    endtask

    task automatic bus_read(input logic [23:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = video_data_out;
    endtask

    task automatic flip_frame();
        frame_end_tgl = ~frame_end_tgl;
        exp_frames++;
    endtask

    task automatic test_reset();
        n_reset = 1'b1;
        sel = 1'b0; wren = 4'b0000; address = '0; video_data_in = '0;
        line_end_tgl = 1'b0; frame_end_tgl = 1'b0;
        #2 n_reset = 1'b0;
        #10;
        sb.push_back('{"reset_rgb", 32'h0});
        sb.push_back('{"reset_irq", 32'h0});
        sb.push_back('{"reset_ctrl", 32'h0});
        sb.push_back('{"reset_status", 32'h0});
        obs = {8'h0, rgb_data}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        obs = {31'h0, irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h00, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h04, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        #9 n_reset = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_immediate_colour();
        bus_write(24'h8C, 32'h00FF8040, 4'hF, 1'b1);
        bus_write(24'h00, 32'h00000301, 4'hF, 1'b1);
        sb.push_back('{"rgb_before_update", 32'h0});
        obs = {8'h0, rgb_data}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        wait_cycles(1);
        sb.push_back('{"rgb_immediate", 32'h00FF8040});
        sb.push_back('{"ctrl_readback", 32'h00000301});
        sb.push_back('{"status_active3", 32'h00000300});
        sb.push_back('{"pal3_readback", 32'h00FF8040});
        obs = {8'h0, rgb_data}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h00, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h04, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h8C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_write(24'h00, 32'h00000300, 4'hF, 1'b1);
        wait_cycles(1);
        sb.push_back('{"rgb_disabled", 32'h0});
        obs = {8'h0, rgb_data}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
    endtask

    task automatic test_frame_commit();
        bus_write(24'h00, 32'h00000501, 4'hF, 1'b1);
        bus_write(24'h00, 32'h00000703, 4'hF, 1'b1);
        sb.push_back('{"commit_armed", 32'h00000504});
        bus_read(24'h04, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        flip_frame();
        sb.push_back('{"commit_not_yet_E2", 32'h00000504});
        sb.push_back('{"commit_done_E3", 32'h00000701});
        sb.push_back('{"frame_cnt_1", 32'(exp_frames)});
        wait_cycles(3);
        bus_read(24'h04, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        wait_cycles(1);
        bus_read(24'h04, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h10, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
    endtask

    task automatic test_line_count();
        for (int i = 0; i < 1030; i++) begin
            line_end_tgl = ~line_end_tgl;
            wait_cycles(2);
        end
        wait_cycles(2);
        sb.push_back('{"line_cnt_saturated", 32'd1023});
        sb.push_back('{"line_pend_set", 32'h2});
        bus_read(24'h0C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h04, obs); obs = obs & 32'h2; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        flip_frame();
        sb.push_back('{"line_cnt_frame_clear", 32'd0});
        sb.push_back('{"frame_cnt_2", 32'(exp_frames)});
        wait_cycles(4);
        bus_read(24'h0C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h10, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            line_end_tgl = ~line_end_tgl;
            wait_cycles(2);
        end
        wait_cycles(2);
        bus_write(24'h04, 32'h00000003, 4'hF, 1'b1);
        sb.push_back('{"line_cnt_5", 32'd5});
        sb.push_back('{"pend_w1c_cleared", 32'h0});
        bus_read(24'h0C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h04, obs); obs = obs & 32'h3; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        line_end_tgl = ~line_end_tgl;
        flip_frame();
        sb.push_back('{"simul_line_cnt", 32'd0});
        sb.push_back('{"simul_pend_both", 32'h3});
        sb.push_back('{"frame_cnt_3", 32'(exp_frames)});
        wait_cycles(4);
        bus_read(24'h0C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h04, obs); obs = obs & 32'h3; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h10, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
    endtask

    task automatic test_interrupt();
        bus_write(24'h04, 32'h00000003, 4'hF, 1'b1);
        bus_write(24'h08, 32'h00000001, 4'hF, 1'b1);
        wait_cycles(1);
        sb.push_back('{"irq_idle", 32'h0});
        obs = {31'h0, irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        flip_frame();
        sb.push_back('{"frame_pend_E3", 32'h1});
        sb.push_back('{"irq_not_yet_E3", 32'h0});
        sb.push_back('{"irq_at_E4", 32'h1});
        wait_cycles(4);
        bus_read(24'h04, obs); obs = obs & 32'h1; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        obs = {31'h0, irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        wait_cycles(1);
        obs = {31'h0, irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        flip_frame();
        wait_cycles(3);
        bus_write(24'h04, 32'h00000001, 4'hF, 1'b1);
        sb.push_back('{"set_beats_w1c", 32'h1});
        sb.push_back('{"frame_cnt_5", 32'(exp_frames)});
        bus_read(24'h04, obs); obs = obs & 32'h1; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h10, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        wait_cycles(2);
        bus_write(24'h04, 32'h00000001, 4'hF, 1'b1);
        sb.push_back('{"quiet_w1c", 32'h0});
        sb.push_back('{"irq_lags_w1c", 32'h1});
        sb.push_back('{"irq_dropped", 32'h0});
        bus_read(24'h04, obs); obs = obs & 32'h1; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        obs = {31'h0, irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        wait_cycles(1);
        obs = {31'h0, irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
    endtask

    task automatic test_byte_enables();
        bus_write(24'h80, 32'hFFFFFFFF, 4'b0001, 1'b1);
        bus_write(24'h84, 32'hAABBCCDD, 4'b0100, 1'b1);
        bus_write(24'h80, 32'h12345678, 4'hF, 1'b0);
        bus_write(24'h14, 32'hFFFFFFFF, 4'hF, 1'b1);
        bus_write(24'hC0, 32'hFFFFFFFF, 4'hF, 1'b1);
        bus_write(24'h08, 32'h00000000, 4'b0010, 1'b1);
        sb.push_back('{"pal0_byte0", 32'h000000FF});
        sb.push_back('{"pal1_byte2", 32'h00BB0000});
        sb.push_back('{"unmapped_0x14", 32'h0});
        sb.push_back('{"unmapped_0xC0", 32'h0});
        sb.push_back('{"irq_en_lane", 32'h1});
        bus_read(24'h80, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h84, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h14, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'hC0, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h08, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus_write(24'h88, 32'h0000AA55, 4'hF, 1'b1);
        bus_write(24'h90, 32'h00123456, 4'hF, 1'b1);
        bus_write(24'h00, 32'h00000203, 4'hF, 1'b1);
        sb.push_back('{"rearm_status", 32'h00000704});
        bus_read(24'h04, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        flip_frame();
        wait_cycles(3);
        bus_write(24'h00, 32'h00000903, 4'hF, 1'b1);
        sb.push_back('{"collide_status", 32'h00000205});
        sb.push_back('{"collide_ctrl", 32'h00000903});
        sb.push_back('{"collide_rgb", 32'h0000AA55});
        bus_read(24'h04, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h00, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        wait_cycles(1);
        obs = {8'h0, rgb_data}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_write(24'h00, 32'h00000401, 4'hF, 1'b1);
        sb.push_back('{"mode0_overrides_pend", 32'h00000401});
        sb.push_back('{"mode0_rgb", 32'h00123456});
        bus_read(24'h04, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        wait_cycles(1);
        obs = {8'h0, rgb_data}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        sb.push_back('{"irq_before_reset", 32'h1});
        obs = {31'h0, irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        #2;
        n_reset = 1'b0;
        frame_end_tgl = 1'b1;
        exp_frames = 0;
        #1;
        sb.push_back('{"mid_reset_rgb", 32'h0});
        sb.push_back('{"mid_reset_irq", 32'h0});
        sb.push_back('{"mid_reset_status", 32'h0});
        sb.push_back('{"mid_reset_line", 32'h0});
        sb.push_back('{"mid_reset_frame", 32'h0});
        sb.push_back('{"mid_reset_pal", 32'h0});
        obs = {8'h0, rgb_data}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        obs = {31'h0, irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h04, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h0C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h10, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        bus_read(24'h8C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
        @(negedge clk_cpu);
        n_reset = 1'b1;
        exp_frames++;
        sb.push_back('{"spurious_frame_event", 32'(exp_frames)});
        wait_cycles(4);
        bus_read(24'h10, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_immediate_colour();
        test_frame_commit();
        test_line_count();
        test_interrupt();
        test_byte_enables();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
